// File: rtl/count_down_timer_ctrl.sv
// count_down_timer_ctrl: key sequencer for count_down_timer (H/M/S edit, run/pause, alarm).
// Build option: define HOUR_99_EN for a 00-99 hour range instead of 00-23.
module count_down_timer_ctrl #(
  parameter int PULSE_CYCLES  = 2,
  parameter int RING_MS       = 10000,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic       clk_1k,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_start,
  input  logic       counting,
  input  logic       ring,
  output logic [7:0] hour_bcd_out,
  output logic [7:0] minute_bcd_out,
  output logic [7:0] second_bcd_out,
  output logic       set,
  output logic       play,
  output logic       stop,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic       buzzer_en
);

  localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int RCW = (RING_MS > 1) ? $clog2(RING_MS) : 1;
  localparam int BCW = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;

  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);
  localparam logic [RCW-1:0] RING_LAST  = RCW'(RING_MS - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_HALF_MS - 1);

`ifdef HOUR_99_EN
  localparam logic [7:0] HOUR_MAX = 8'h99;
`else
  localparam logic [7:0] HOUR_MAX = 8'h23;
`endif

  typedef enum logic [2:0] {
    IDLE, EDIT_H, EDIT_M, EDIT_S, LOAD, RUN, PAUSE, ALARM
  } state_t;

  state_t state_reg, state_next;

  logic           set_reg, play_reg, stop_reg;
  logic [PCW-1:0] pulse_cnt_reg;
  logic           issue_set, issue_play, issue_stop, issue_any;
  logic           busy, strobe_last;

  logic           ring_q_reg, counting_q_reg;
  logic           ring_rise, count_fall;
  logic [RCW-1:0] alarm_cnt_reg;
  logic           alarm_done;

  logic           blink_reg;
  logic [BCW-1:0] blink_cnt_reg;
  logic           edit_now, edit_next, blink_restart;

  logic           start_go, mode_go, inc_go, any_key_go;
  logic [7:0]     field_value [3];
  logic           preset_nz;

  function automatic logic is_edit(input state_t s);
    return (s == EDIT_H) || (s == EDIT_M) || (s == EDIT_S);
  endfunction

  // BCD increment with wrap at max; the low nibble carries 9 -> high nibble.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Keys are only honoured while no strobe is in flight; start > mode > inc.
  assign busy        = set_reg | play_reg | stop_reg;
  assign strobe_last = busy && (pulse_cnt_reg == PULSE_LAST);
  assign start_go    = !busy && key_start;
  assign mode_go     = !busy && key_mode && !key_start;
  assign inc_go      = !busy && key_inc && !key_mode && !key_start;
  assign any_key_go  = !busy && (key_start || key_mode || key_inc);

  assign ring_rise   = ring && !ring_q_reg;
  assign count_fall  = counting_q_reg && !counting;
  assign alarm_done  = (alarm_cnt_reg == RING_LAST);
  assign preset_nz   = |{field_value[0], field_value[1], field_value[2]};

  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    issue_set  = 1'b0;
    issue_play = 1'b0;
    issue_stop = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_go) begin
          if (preset_nz) begin
            state_next = LOAD;
            issue_set  = 1'b1;
          end
        end else if (mode_go) begin
          state_next = EDIT_H;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        if (start_go) begin
          if (preset_nz) begin
            state_next = LOAD;
            issue_set  = 1'b1;
          end
        end else if (mode_go) begin
          case (state_reg)
            EDIT_H:  state_next = EDIT_M;
            EDIT_M:  state_next = EDIT_S;
            default: state_next = IDLE;
          endcase
        end
      end
      LOAD: begin
        // play follows set with no gap
        if (strobe_last) begin
          state_next = RUN;
          issue_play = 1'b1;
        end
      end
      RUN: begin
        if (ring_rise) begin
          state_next = ALARM;
        end else if (count_fall && !ring) begin
          state_next = IDLE;
        end else if (start_go) begin
          state_next = PAUSE;
          issue_stop = 1'b1;
        end
      end
      PAUSE: begin
        if (ring_rise) begin
          state_next = ALARM;
        end else if (start_go) begin
          state_next = RUN;
          issue_play = 1'b1;
        end else if (mode_go) begin
          state_next = IDLE;
          issue_set  = 1'b1;
        end
      end
      ALARM: begin
        // the clearing key is consumed here and has no further effect
        if (any_key_go || (alarm_done && !busy)) begin
          state_next = IDLE;
          issue_set  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign issue_any = issue_set | issue_play | issue_stop;

  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      set_reg       <= 1'b0;
      play_reg      <= 1'b0;
      stop_reg      <= 1'b0;
      pulse_cnt_reg <= '0;
    end else if (issue_any) begin
      set_reg       <= issue_set;
      play_reg      <= issue_play;
      stop_reg      <= issue_stop;
      pulse_cnt_reg <= '0;
    end else if (busy) begin
      if (pulse_cnt_reg == PULSE_LAST) begin
        set_reg  <= 1'b0;
        play_reg <= 1'b0;
        stop_reg <= 1'b0;
      end else begin
        pulse_cnt_reg <= pulse_cnt_reg + PCW'(1);
      end
    end
  end

  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      ring_q_reg     <= 1'b0;
      counting_q_reg <= 1'b0;
      alarm_cnt_reg  <= '0;
    end else begin
      ring_q_reg     <= ring;
      counting_q_reg <= counting;
      if (state_reg != ALARM)
        alarm_cnt_reg <= '0;
      else if (!alarm_done)
        alarm_cnt_reg <= alarm_cnt_reg + RCW'(1);
    end
  end

  // Preset fields: 0 hour, 1 minute, 2 second; each edited only in its own state.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      localparam state_t     FIELD_STATE = (gi == 0) ? EDIT_H : ((gi == 1) ? EDIT_M : EDIT_S);
      localparam logic [7:0] FIELD_MAX   = (gi == 0) ? HOUR_MAX : 8'h59;
      logic [7:0] value_reg;
      always_ff @(posedge clk_1k or posedge rst) begin
        if (rst)
          value_reg <= 8'h00;
        else if (inc_go && (state_reg == FIELD_STATE))
          value_reg <= bcd_inc(value_reg, FIELD_MAX);
      end
      assign field_value[gi] = value_reg;
    end
  endgenerate

  assign edit_now      = is_edit(state_reg);
  assign edit_next     = is_edit(state_next);
  assign blink_restart = (edit_next && (state_next != state_reg)) || (inc_go && edit_now);

  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      blink_reg     <= 1'b1;
      blink_cnt_reg <= '0;
    end else if (!edit_next || blink_restart) begin
      blink_reg     <= 1'b1;
      blink_cnt_reg <= '0;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_reg     <= !blink_reg;
      blink_cnt_reg <= '0;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BCW'(1);
    end
  end

  always_comb begin
    edit_field = 2'd0;
    case (state_reg)
      EDIT_H:  edit_field = 2'd1;
      EDIT_M:  edit_field = 2'd2;
      EDIT_S:  edit_field = 2'd3;
      default: edit_field = 2'd0;
    endcase
  end

  assign hour_bcd_out   = field_value[0];
  assign minute_bcd_out = field_value[1];
  assign second_bcd_out = field_value[2];
  assign set            = set_reg;
  assign play           = play_reg;
  assign stop           = stop_reg;
  assign blink          = blink_reg;
  assign buzzer_en      = (state_reg == ALARM) && ring;

endmodule

// File: tb/tb_count_down_timer_ctrl.sv
// tb_count_down_timer_ctrl: directed stimulus; strobe expectations are queued and
// checked by a decoupled monitor, static outputs checked inline.
module tb_count_down_timer_ctrl;

  localparam int P     = 2;
  localparam int RING  = 40;
  localparam int BHALF = 5;

`ifdef HOUR_99_EN
  localparam int         HOUR_STEPS = 89;
  localparam logic [7:0] HOUR_TOP   = 8'h99;
`else
  localparam int         HOUR_STEPS = 13;
  localparam logic [7:0] HOUR_TOP   = 8'h23;
`endif

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] SET  = 3'b001;
  localparam logic [2:0] PLAY = 3'b010;
  localparam logic [2:0] STOP = 3'b100;

  localparam logic [2:0] K_INC   = 3'b001;
  localparam logic [2:0] K_MODE  = 3'b010;
  localparam logic [2:0] K_START = 3'b100;

  logic       clk_1k = 1'b0;
  logic       rst;
  logic       key_mode, key_inc, key_start, counting, ring;
  logic [7:0] hour_bcd_out, minute_bcd_out, second_bcd_out;
  logic       set, play, stop, blink, buzzer_en;
  logic [1:0] edit_field;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  kind;
    int          at;
    logic [23:0] preset;
  } exp_t;
  exp_t q[$];

  count_down_timer_ctrl #(
    .PULSE_CYCLES (P),
    .RING_MS      (RING),
    .BLINK_HALF_MS(BHALF)
  ) dut (
    .clk_1k        (clk_1k),
    .rst           (rst),
    .key_mode      (key_mode),
    .key_inc       (key_inc),
    .key_start     (key_start),
    .counting      (counting),
    .ring          (ring),
    .hour_bcd_out  (hour_bcd_out),
    .minute_bcd_out(minute_bcd_out),
    .second_bcd_out(second_bcd_out),
    .set           (set),
    .play          (play),
    .stop          (stop),
    .edit_field    (edit_field),
    .blink         (blink),
    .buzzer_en     (buzzer_en)
  );

  always #5 clk_1k = ~clk_1k;
  always @(posedge clk_1k) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int at, input logic [23:0] pre);
    exp_t e;
    e.kind = kind;
    e.at = at;
    e.preset = pre;
    q.push_back(e);
  endtask

  // Key asserted for one cycle; expected strobes are queued before the sampling edge.
  task automatic press(input logic [2:0] keys, input logic [2:0] k1, input logic [2:0] k2,
                       input logic [23:0] pre);
    int at;
    @(negedge clk_1k);
    {key_start, key_mode, key_inc} = keys;
    at = cyc;
    if (k1 != NONE) push(k1, at + 1, pre);
    if (k2 != NONE) push(k2, at + 1 + P, pre);
    @(negedge clk_1k);
    {key_start, key_mode, key_inc} = 3'b000;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_1k);
  endtask

  task automatic monitor();
    logic [2:0] prev, cur;
    int width;
    exp_t e;
    prev = 3'b000;
    width = 0;
    forever begin
      @(negedge clk_1k);
      if (rst) begin
        prev = 3'b000;
        width = 0;
      end else begin
        cur = {stop, play, set};
        if (cur != prev) begin
          if (prev != 3'b000) check("strobe_width", width, P);
          if (cur != 3'b000) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_strobe actual=%b required=none (cycle %0d)", cur, cyc);
            end else begin
              e = q.pop_front();
              $display("strobe %b at cycle %0d preset %h", cur, cyc,
                       {hour_bcd_out, minute_bcd_out, second_bcd_out});
              check("strobe_kind", cur, e.kind);
              check("strobe_cycle", cyc, e.at);
              check("strobe_preset", {hour_bcd_out, minute_bcd_out, second_bcd_out}, e.preset);
            end
            width = 0;
          end
        end
        if (cur != 3'b000) width++;
        prev = cur;
      end
    end
  endtask

  initial begin
    key_mode = 0; key_inc = 0; key_start = 0; counting = 0; ring = 0; rst = 1;
    fork
      monitor();
    join_none

    // reset
    wait_cycles(3);
    #1 rst = 0;
    @(negedge clk_1k);
    check("rst_strobes", {set, play, stop}, 3'b000);
    check("rst_preset", {hour_bcd_out, minute_bcd_out, second_bcd_out}, 24'h000000);
    check("rst_edit_field", edit_field, 2'd0);
    check("rst_blink", blink, 1'b1);
    check("rst_buzzer", buzzer_en, 1'b0);

    // edit 03:00:03 and start
    press(K_MODE, NONE, NONE, 0);
    check("edit_h", edit_field, 2'd1);
    repeat (3) press(K_INC, NONE, NONE, 0);
    press(K_MODE, NONE, NONE, 0);
    check("edit_m", edit_field, 2'd2);
    press(K_MODE, NONE, NONE, 0);
    check("edit_s", edit_field, 2'd3);
    repeat (3) press(K_INC, NONE, NONE, 0);
    check("preset_030003", {hour_bcd_out, minute_bcd_out, second_bcd_out}, 24'h030003);
    press(K_START, SET, PLAY, 24'h030003);
    wait_cycles(2 * P + 2);
    check("load_edit_field", edit_field, 2'd0);
    counting = 1;

    // pause / resume
    press(K_START, STOP, NONE, 24'h030003);
    wait_cycles(P + 2);
    press(K_START, PLAY, NONE, 24'h030003);
    wait_cycles(P + 2);

    // key while stop strobe active is dropped
    press(K_START, STOP, NONE, 24'h030003);
    press(K_START, NONE, NONE, 0);
    wait_cycles(P + 2);
    press(K_START, PLAY, NONE, 24'h030003);
    wait_cycles(P + 2);

    // ring in RUN, alarm times out
    @(negedge clk_1k);
    ring = 1;
    counting = 0;
    push(SET, cyc + 1 + RING, 24'h030003);
    @(negedge clk_1k);
    check("alarm_buzzer_on", buzzer_en, 1'b1);
    wait_cycles(RING + P + 2);
    check("alarm_buzzer_off", buzzer_en, 1'b0);
    check("alarm_idle_field", edit_field, 2'd0);
    ring = 0;

    // blink in EDIT_H
    press(K_MODE, NONE, NONE, 0);
    check("blink_entry", blink, 1'b1);
    wait_cycles(BHALF - 1);
    check("blink_half_end", blink, 1'b1);
    wait_cycles(1);
    check("blink_toggle", blink, 1'b0);
    press(K_INC, NONE, NONE, 0);
    check("blink_inc_restart", blink, 1'b1);
    check("hour_04", hour_bcd_out, 8'h04);

    // hour carry and wrap
    repeat (6) press(K_INC, NONE, NONE, 0);
    check("hour_carry_10", hour_bcd_out, 8'h10);
    repeat (HOUR_STEPS) press(K_INC, NONE, NONE, 0);
    check("hour_top", hour_bcd_out, HOUR_TOP);
    press(K_INC, NONE, NONE, 0);
    check("hour_wrap", hour_bcd_out, 8'h00);

    // second wrap
    press(K_MODE, NONE, NONE, 0);
    press(K_MODE, NONE, NONE, 0);
    repeat (56) press(K_INC, NONE, NONE, 0);
    check("second_59", second_bcd_out, 8'h59);
    press(K_INC, NONE, NONE, 0);
    check("second_wrap", second_bcd_out, 8'h00);
    check("minute_hold", minute_bcd_out, 8'h00);

    // start+inc with zero preset ignored
    press(K_START | K_INC, NONE, NONE, 0);
    check("zero_start_second", second_bcd_out, 8'h00);
    check("zero_start_field", edit_field, 2'd3);
    press(K_MODE, NONE, NONE, 0);
    check("back_to_idle", edit_field, 2'd0);
    press(K_START, NONE, NONE, 0);
    check("idle_zero_start", edit_field, 2'd0);

    // PAUSE -> mode -> reload -> IDLE
    press(K_MODE, NONE, NONE, 0);
    press(K_INC, NONE, NONE, 0);
    repeat (3) press(K_MODE, NONE, NONE, 0);
    press(K_START, SET, PLAY, 24'h010000);
    wait_cycles(2 * P + 2);
    counting = 1;
    press(K_START, STOP, NONE, 24'h010000);
    wait_cycles(P + 2);
    press(K_MODE, SET, NONE, 24'h010000);
    wait_cycles(P + 2);
    press(K_MODE, NONE, NONE, 0);
    check("pause_mode_idle", edit_field, 2'd1);
    repeat (3) press(K_MODE, NONE, NONE, 0);

    // alarm cleared by a key that has no other effect
    press(K_START, SET, PLAY, 24'h010000);
    wait_cycles(2 * P + 2);
    @(negedge clk_1k);
    ring = 1;
    counting = 0;
    @(negedge clk_1k);
    check("alarm2_buzzer_on", buzzer_en, 1'b1);
    press(K_MODE, SET, NONE, 24'h010000);
    check("alarm_key_field", edit_field, 2'd0);
    check("alarm_key_buzzer", buzzer_en, 1'b0);
    ring = 0;
    wait_cycles(P + 2);

    // counting falls in RUN -> IDLE without a strobe
    press(K_START, SET, PLAY, 24'h010000);
    wait_cycles(2 * P + 2);
    counting = 1;
    wait_cycles(3);
    counting = 0;
    wait_cycles(2);
    press(K_MODE, NONE, NONE, 0);
    check("count_fall_idle", edit_field, 2'd1);

    // reset during a set strobe
    press(K_START, SET, NONE, 24'h010000);
    #1 rst = 1;
    #1;
    check("rst_mid_strobe", {set, play, stop}, 3'b000);
    check("rst_mid_preset", {hour_bcd_out, minute_bcd_out, second_bcd_out}, 24'h000000);
    wait_cycles(2);
    #1 rst = 0;
    @(negedge clk_1k);
    check("rst_mid_field", edit_field, 2'd0);
    check("rst_mid_blink", blink, 1'b1);

    wait_cycles(2 * P + 4);
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
